// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button synchroniser, debouncer and press/release pulse generator
// Optional auto-repeat on held buttons is compiled in with `define BTN_REPEAT_EN.
module btn_debounce #(
    parameter int N_BTN          = 4,
    parameter int DEB_CYCLES     = 160000,
    parameter int BTN_ACTIVE_LOW = 1,
    parameter int REPEAT_DELAY   = 4000000,
    parameter int REPEAT_PERIOD  = 1600000
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [N_BTN-1:0] RAW_RELEASED =
        (BTN_ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    // Parameter legality is enforced at elaboration so a bad build never reaches silicon.
    if (N_BTN < 1) begin : g_bad_n_btn
        $error("btn_debounce: N_BTN must be at least 1");
    end
    if (DEB_CYCLES < 2 || DEB_CYCLES > (1 << 20)) begin : g_bad_deb_cycles
        $error("btn_debounce: DEB_CYCLES must be within 2..2^20");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("btn_debounce: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] s;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sync1 <= RAW_RELEASED;
            sync2 <= RAW_RELEASED;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign s = (BTN_ACTIVE_LOW != 0) ? ~sync2 : sync2;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_t        state;
        state_t        state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic [CW-1:0] cnt_inc;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic          level_nxt;
        logic          press_nxt;
        logic          release_nxt;
        logic          rep_fire;

        assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            level_nxt   = level_q;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            case (state)
                IDLE: begin
                    if (s[i]) begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!s[i]) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                        level_nxt = 1'b1;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                HELD: begin
                    if (!s[i]) begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = CNT_ONE;
                    end else begin
                        press_nxt = rep_fire;
                    end
                end
                RELEASE_WAIT: begin
                    if (s[i]) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt   = IDLE;
                        cnt_nxt     = '0;
                        level_nxt   = 1'b0;
                        release_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end
            endcase
        end

        always_ff @(posedge sys_clk or negedge reset) begin
            if (!reset) begin
                state     <= IDLE;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
            end
        end

`ifdef BTN_REPEAT_EN
        localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RCW  = $clog2(RMAX) + 1;
        localparam logic [RCW-1:0] RD_LAST = RCW'(REPEAT_DELAY - 1);
        localparam logic [RCW-1:0] RP_LAST = RCW'(REPEAT_PERIOD - 1);

        logic [RCW-1:0] rcnt;
        logic [RCW-1:0] rcnt_nxt;
        logic           rep_periodic;
        logic           rep_periodic_nxt;

        // Counts only while settled in HELD; a pending release freezes it, leaving HELD
        // for good (IDLE/PRESS_WAIT) clears it.
        always_comb begin
            rcnt_nxt         = rcnt;
            rep_periodic_nxt = rep_periodic;
            rep_fire         = 1'b0;
            if (state == HELD && s[i]) begin
                if (rcnt == (rep_periodic ? RP_LAST : RD_LAST)) begin
                    rep_fire         = 1'b1;
                    rcnt_nxt         = '0;
                    rep_periodic_nxt = 1'b1;
                end else begin
                    rcnt_nxt = rcnt + {{(RCW-1){1'b0}}, 1'b1};
                end
            end else if (state == IDLE || state == PRESS_WAIT) begin
                rcnt_nxt         = '0;
                rep_periodic_nxt = 1'b0;
            end
        end

        always_ff @(posedge sys_clk or negedge reset) begin
            if (!reset) begin
                rcnt         <= '0;
                rep_periodic <= 1'b0;
            end else begin
                rcnt         <= rcnt_nxt;
                rep_periodic <= rep_periodic_nxt;
            end
        end
`else
        assign rep_fire = 1'b0;
`endif

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - self-checking bench for btn_debounce against a run-length debounce model
module tb_btn_debounce;

    localparam int N  = 4;
    localparam int DEB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic         sys_clk = 1'b0;
    logic         reset   = 1'b0;
    logic [N-1:0] btn_raw = 4'b0000;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    int errors = 0;
    int checks = 0;
    logic started = 1'b0;

    btn_debounce #(
        .N_BTN(N),
        .DEB_CYCLES(DEB),
        .BTN_ACTIVE_LOW(1),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .sys_clk(sys_clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the pressed view of each pin, two samples late; a level flips once the
    // sampled value has disagreed with it for DEB consecutive samples.
    logic [N-1:0] m_h1, m_h2, m_level, m_press, m_release;
    int run [N];
`ifdef BTN_REPEAT_EN
    int hold [N];
`endif

    always @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            m_h1 <= '0;
            m_h2 <= '0;
            m_level <= '0;
            m_press <= '0;
            m_release <= '0;
            for (int i = 0; i < N; i++) begin
                run[i] <= 0;
`ifdef BTN_REPEAT_EN
                hold[i] <= 0;
`endif
            end
        end else begin
            m_h1 <= ~btn_raw;
            m_h2 <= m_h1;
            for (int i = 0; i < N; i++) begin
                m_press[i] <= 1'b0;
                m_release[i] <= 1'b0;
                if (m_h2[i] != m_level[i]) begin
                    if (run[i] + 1 == DEB) begin
                        m_level[i] <= m_h2[i];
                        run[i] <= 0;
`ifdef BTN_REPEAT_EN
                        hold[i] <= 0;
`endif
                        if (m_h2[i]) m_press[i] <= 1'b1;
                        else m_release[i] <= 1'b1;
                    end else begin
                        run[i] <= run[i] + 1;
                    end
                end else begin
                    run[i] <= 0;
`ifdef BTN_REPEAT_EN
                    if (m_level[i] && run[i] == 0) begin
                        hold[i] <= hold[i] + 1;
                        if (hold[i] + 1 == RD || (hold[i] + 1 > RD && (hold[i] + 1 - RD) % RP == 0))
                            m_press[i] <= 1'b1;
                    end
`endif
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        if (started) begin
            check("level_vs_model", btn_level, m_level);
            check("press_vs_model", btn_press, m_press);
            check("release_vs_model", btn_release, m_release);
            check("press_release_exclusive", btn_press & btn_release, 4'b0000);
        end
    end

    task automatic negs(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    int cnt_press;
    logic [N-1:0] seen;

    initial begin
        negs(2);
        started = 1'b1;

        // Reset held with every button pressed
        negs(3);
        check("reset_level", btn_level, 4'b0000);
        check("reset_press", btn_press, 4'b0000);
        check("reset_release", btn_release, 4'b0000);
        reset = 1'b1;
        negs(5);
        check("post_reset_press_early", btn_press, 4'b0000);
        negs(1);
        check("post_reset_press", btn_press, 4'b1111);
        check("post_reset_level", btn_level, 4'b1111);
        negs(1);
        check("post_reset_press_one_cycle", btn_press, 4'b0000);

        // Release all
        btn_raw = 4'b1111;
        negs(6);
        check("release_all", btn_release, 4'b1111);
        check("release_all_level", btn_level, 4'b0000);
        negs(6);

        // Clean press on bit0, held 20 cycles, then release
        btn_raw = 4'b1110;
        negs(5);
        check("press0_early", btn_press, 4'b0000);
        negs(1);
        check("press0_pulse", btn_press, 4'b0001);
        check("press0_level", btn_level, 4'b0001);
        negs(1);
        check("press0_one_cycle", btn_press, 4'b0000);
        check("press0_level_held", btn_level, 4'b0001);
        negs(13);
        btn_raw = 4'b1111;
        negs(5);
        check("release0_early", btn_release, 4'b0000);
        negs(1);
        check("release0_pulse", btn_release, 4'b0001);
        check("release0_level", btn_level, 4'b0000);
        negs(6);

        // Bounce on bit2: low 3, high 2, low 3, then high
        seen = '0;
        btn_raw = 4'b1011;
        for (int k = 0; k < 3; k++) begin negs(1); seen |= btn_level | btn_press | btn_release; end
        btn_raw = 4'b1111;
        for (int k = 0; k < 2; k++) begin negs(1); seen |= btn_level | btn_press | btn_release; end
        btn_raw = 4'b1011;
        for (int k = 0; k < 3; k++) begin negs(1); seen |= btn_level | btn_press | btn_release; end
        btn_raw = 4'b1111;
        for (int k = 0; k < 12; k++) begin negs(1); seen |= btn_level | btn_press | btn_release; end
        check("bounce_no_activity", seen, 4'b0000);

        // Simultaneous presses on bits 1 and 3
        btn_raw = 4'b0101;
        negs(6);
        check("simul_press", btn_press, 4'b1010);
        check("simul_level", btn_level, 4'b1010);
        btn_raw = 4'b1111;
        negs(6);
        check("simul_release", btn_release, 4'b1010);
        negs(4);

        // Held press on bit0: auto-repeat pulses only when compiled in
        btn_raw = 4'b1110;
        negs(6);
        check("hold_press", btn_press, 4'b0001);
        cnt_press = 0;
        for (int k = 0; k < 46; k++) begin
            negs(1);
            if (btn_press[0]) cnt_press++;
        end
`ifdef BTN_REPEAT_EN
        check_int("repeat_count", cnt_press, 4);
`else
        check_int("repeat_count", cnt_press, 0);
`endif
        btn_raw = 4'b1111;
        cnt_press = 0;
        for (int k = 0; k < 10; k++) begin
            negs(1);
            if (btn_press[0]) cnt_press++;
        end
        check_int("no_press_during_release", cnt_press, 0);
        check("hold_released_level", btn_level, 4'b0000);

        // Reset mid-debounce with bit0 still held: fresh press after reset
        btn_raw = 4'b1110;
        negs(3);
        reset = 1'b0;
        negs(2);
        check("midreset_level", btn_level, 4'b0000);
        reset = 1'b1;
        negs(5);
        check("midreset_press_early", btn_press, 4'b0000);
        negs(1);
        check("midreset_press", btn_press, 4'b0001);
        btn_raw = 4'b1111;
        negs(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
